// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter with a circular TX FIFO, programmable baud
// divider and optional parity / two stop bits.
module uart_tx_fifo #(
   parameter int FIFO_DEPTH  = 16,
   parameter int DATA_BITS   = 8,
   parameter int DEFAULT_DIV = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   input  logic        wstrb,
   input  logic        rstrb,
   output logic [31:0] rdata,
   output logic        txd,
   output logic        irq
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
   localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   state_t state, state_nxt;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [LW-1:0]        level;
   logic [15:0]          div_reg;
   logic [2:0]           ctrl_reg;
   logic                 ovf;

   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit, par_en_l, two_stop_l, stop2;
   logic [15:0]          div_l, cnt, div_eff;
   logic [2:0]           bit_idx;

   logic wr_data, wr_status, wr_div, wr_ctrl, rd_en;
   logic full, empty, pop, push, ovf_set, bit_end;
   logic [31:0] status;
   logic unused_wdata;

   always_comb begin
      wr_data   = sel & wstrb & (addr == 2'd0);
      wr_status = sel & wstrb & (addr == 2'd1);
      wr_div    = sel & wstrb & (addr == 2'd2);
      wr_ctrl   = sel & wstrb & (addr == 2'd3);
      rd_en     = sel & rstrb;
      full      = (level == LVL_FULL);
      empty     = (level == '0);
      pop       = (state == S_IDLE) & ~empty;
      push      = wr_data & (~full | pop);
      ovf_set   = wr_data & full & ~pop;
      bit_end   = (cnt == '0);
      div_eff   = (div_reg == '0) ? 16'd1 : div_reg;
      irq       = empty & (state == S_IDLE);
   end

   assign unused_wdata = ^wdata[31:16];

   always_comb begin
      status        = '0;
      status[0]     = (state != S_IDLE);
      status[1]     = empty;
      status[2]     = ovf;
      status[9]     = full;
      status[23:16] = 8'(level);
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (pop) state_nxt = S_START;
         S_START:  if (bit_end) state_nxt = S_DATA;
         S_DATA:   if (bit_end && bit_idx == LAST_BIT)
                      state_nxt = par_en_l ? S_PARITY : S_STOP;
         S_PARITY: if (bit_end) state_nxt = S_STOP;
         S_STOP:   if (bit_end && (!two_stop_l || stop2)) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      txd = 1'b1;
      unique case (state)
         S_START:  txd = 1'b0;
         S_DATA:   txd = shreg[0];
         S_PARITY: txd = par_bit;
         default:  txd = 1'b1;
      endcase
   end

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= wdata[DATA_BITS-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         ovf      <= 1'b0;
         div_reg  <= 16'(DEFAULT_DIV);
         ctrl_reg <= '0;
         rdata    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         // set beats clear when both land in the same cycle
         if (ovf_set) ovf <= 1'b1;
         else if (wr_status && wdata[2]) ovf <= 1'b0;
         if (wr_div)  div_reg  <= wdata[15:0];
         if (wr_ctrl) ctrl_reg <= wdata[2:0];
         if (rd_en) begin
            case (addr)
               2'd0:    rdata <= '0;
               2'd1:    rdata <= status;
               2'd2:    rdata <= {16'd0, div_reg};
               default: rdata <= {29'd0, ctrl_reg};
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         shreg      <= '0;
         par_bit    <= 1'b0;
         par_en_l   <= 1'b0;
         two_stop_l <= 1'b0;
         stop2      <= 1'b0;
         div_l      <= 16'd1;
         cnt        <= '0;
         bit_idx    <= '0;
      end else begin
         state <= state_nxt;
         if (pop) begin
            // divider and framing are frozen per frame at pop time
            shreg      <= mem[rd_ptr];
            par_bit    <= (^mem[rd_ptr]) ^ ctrl_reg[1];
            par_en_l   <= ctrl_reg[0];
            two_stop_l <= ctrl_reg[2];
            div_l      <= div_eff;
            cnt        <= div_eff - 16'd1;
            bit_idx    <= '0;
            stop2      <= 1'b0;
         end else if (state != S_IDLE) begin
            if (!bit_end) begin
               cnt <= cnt - 16'd1;
            end else begin
               cnt <= div_l - 16'd1;
               if (state == S_DATA) begin
                  shreg   <= shreg >> 1;
                  bit_idx <= bit_idx + 3'd1;
               end
               if (state == S_STOP) stop2 <= 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, TX FIFO entries; SHALL be a power of two, 2..256.
REQ-002 Parameter DATA_BITS, default 8, payload bits per frame; legal range 5..8.
REQ-003 Parameter DEFAULT_DIV, default 8, reset value of baud divider (clk cycles per bit).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sel  input  1  peripheral selected (IO page decode done by SOC).
REQ-007 addr  input  2  word offset: 0 DATA, 1 STATUS, 2 DIV, 3 CTRL.
REQ-008 wdata  input  32  write data.
REQ-009 wstrb  input  1  write strobe, one cycle per write.
REQ-010 rstrb  input  1  read strobe, one cycle per read.
REQ-011 rdata  output  32  registered read data, valid the cycle after rstrb.
REQ-012 txd  output  1  serial line, idle high.
REQ-013 irq  output  1  high while FIFO empty and transmitter idle.

Function
REQ-014 Access SHALL occur only when sel=1; wstrb/rstrb with sel=0 SHALL have no effect.
REQ-015 Write DATA: push wdata[DATA_BITS-1:0]; accepted if FIFO not full, or full with a pop in the same cycle.
REQ-016 Write DATA rejected (full, no pop): byte dropped, sticky OVF set.
REQ-017 STATUS read: bit0 tx active, bit1 empty, bit2 OVF, bit9 full (firmware-compatible busy bit), bits[23:16] level (0..FIFO_DEPTH, level FIFO_DEPTH reported in 8 bits as 0 only when FIFO_DEPTH=256 -- then bit9 disambiguates), others 0.
REQ-018 STATUS write with wdata[2]=1 SHALL clear OVF; OVF set and clear in same cycle -> set wins.
REQ-019 DIV: 16-bit RW, rdata[15:0]; value 0 SHALL behave as 1.
REQ-020 CTRL: RW bits[2:0]: bit0 parity enable, bit1 odd parity (0=even), bit2 two stop bits.
REQ-021 DATA read SHALL return 0.
REQ-022 rdata SHALL update only on rstrb&sel, hold otherwise; read latency exactly 1 cycle.
REQ-023 FIFO: circular buffer, log2(FIFO_DEPTH)-bit pointers wrapping modulo depth, separate level counter 0..FIFO_DEPTH.
REQ-024 States: IDLE, START, DATA, PARITY, STOP.
REQ-025 IDLE: txd=1; if FIFO non-empty, pop head into shift register, latch DIV and CTRL, go START.
REQ-026 START: txd=0 for DIV cycles; then DATA.
REQ-027 DATA: DATA_BITS bits LSB first, DIV cycles each; then PARITY if enabled, else STOP.
REQ-028 PARITY: txd = XOR of payload (even) or its inverse (odd), DIV cycles.
REQ-029 STOP: txd=1 for DIV cycles (2*DIV if two stop bits); then IDLE.
REQ-030 Back-to-back: IDLE lasts exactly one cycle between frames when FIFO non-empty.
REQ-031 Latency: DATA write at cycle N into empty FIFO with idle transmitter -> pop at N+1, txd low from N+2.
REQ-032 DIV/CTRL writes mid-frame SHALL affect only subsequent frames.
REQ-033 Bit-time counter 16 bits, counts latched DIV-1 down to 0; no off-by-one: each bit exactly DIV cycles.
REQ-034 irq = (level==0) & state==IDLE, combinational from registered state.

Reset
REQ-035 reset SHALL force: state IDLE, txd=1, rdata=0, FIFO empty (pointers, level 0), OVF=0, DIV=DEFAULT_DIV, CTRL=0; irq=1 next cycle.
REQ-036 reset mid-frame SHALL abort the frame and discard FIFO contents; txd=1 the cycle after reset asserted.
REQ-037 reset SHALL take priority over any simultaneous wstrb/rstrb.

Verification
REQ-038 DIV=4, CTRL=0, write 0x55 -> txd: 4 cycles 0, bits 1,0,1,0,1,0,1,0 at 4 cycles each, 4 cycles 1; irq returns to 1; frame 40 cycles.
REQ-039 CTRL=0x3 (odd parity), CTRL bit2=1, DIV=2, write 0x07 -> parity bit 0 (three ones, odd), stop 4 cycles high; frame 24 cycles.
REQ-040 FIFO_DEPTH=4, DIV=16, write 6 bytes back-to-back -> first popped immediately, 4 queued, sixth dropped; STATUS bit9=1, bit2=1, level=4; write STATUS 0x4 clears bit2.
REQ-041 Fill FIFO, write DATA in the IDLE pop cycle -> byte accepted, level stays FIFO_DEPTH, OVF stays 0; all bytes emitted in order, pointers wrap.
REQ-042 Reset asserted during DATA bit 3 of a frame with 2 bytes queued -> txd=1 next cycle, level=0, DIV=DEFAULT_DIV, no further frames.
REQ-043 DIV=0 write 0xA5 -> each bit 1 cycle; DIV read returns 0; DIV changed to 3 mid-frame -> current frame keeps 1-cycle bits, next frame uses 3.
